// File: rtl/freq_lock_detect.sv
// Frequency lock detector: counts rising edges of a divided feedback clock over a
// fixed window of system clocks and reports measurement, fast/slow flags and lock.
module freq_lock_detect #(
  parameter int WINDOW    = 256,
  parameter int CNT_W     = 9,
  parameter int LOCK_WINS = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_fb_clk,
  input  logic [CNT_W-1:0] i_exp_count,
  input  logic [CNT_W-1:0] i_tol,
  output logic [CNT_W-1:0] o_meas_count,
  output logic             o_meas_valid,
  output logic             o_too_fast,
  output logic             o_too_slow,
  output logic             o_lock
);

  localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int GOOD_W = $clog2(LOCK_WINS + 1);
  localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(WINDOW - 1);
  localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_WINS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_LOCKED
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_s1;
  logic                r_s2;
  logic                r_s3;
  logic [WIN_W-1:0]    r_win_cnt;
  logic [CNT_W-1:0]    r_edge_cnt;
  logic [GOOD_W-1:0]   r_good_cnt;
  logic [GOOD_W-1:0]   w_good_next;
  logic [GOOD_W-1:0]   w_good_inc;
  logic [CNT_W-1:0]    r_meas_count;
  logic                r_meas_valid;
  logic                r_too_fast;
  logic                r_too_slow;
  logic                r_lock;
  logic                w_edge;
  logic                w_active;
  logic                w_win_end;
  logic [CNT_W:0]      w_sum;
  logic [CNT_W-1:0]    w_total;
  logic [CNT_W:0]      w_low;
  logic [CNT_W:0]      w_high;
  logic                w_fast;
  logic                w_slow;
  logic                w_in_range;

  // fb_clk is asynchronous, so it is only ever used after the s1/s2 stages settle it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_fb_clk;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge     = r_s2 & ~r_s3;
  assign w_active   = i_en && (r_state != ST_IDLE);
  assign w_win_end  = w_active && (r_win_cnt == WIN_LAST);
  assign w_sum      = {1'b0, r_edge_cnt} + {{CNT_W{1'b0}}, w_edge};
  assign w_total    = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

  // Bounds live in CNT_W+1 bits so exp+tol cannot wrap; the low bound clamps at zero.
  assign w_low      = (i_exp_count >= i_tol) ? {1'b0, i_exp_count - i_tol} : '0;
  assign w_high     = {1'b0, i_exp_count} + {1'b0, i_tol};
  assign w_fast     = {1'b0, w_total} > w_high;
  assign w_slow     = {1'b0, w_total} < w_low;
  assign w_in_range = !w_fast && !w_slow;
  assign w_good_inc = r_good_cnt + 1'b1;

  always_comb begin
    w_state_next = r_state;
    w_good_next  = r_good_cnt;
    case (r_state)
      ST_IDLE: begin
        w_good_next = '0;
        if (i_en) w_state_next = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (w_win_end) begin
          if (w_in_range) begin
            w_good_next = w_good_inc;
            if (w_good_inc == GOOD_TARGET) w_state_next = ST_LOCKED;
          end else begin
            w_good_next = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (w_win_end && !w_in_range) begin
          w_state_next = ST_ACQUIRE;
          w_good_next  = '0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_good_next  = '0;
      end
    endcase
    if (!i_en) begin
      w_state_next = ST_IDLE;
      w_good_next  = '0;
    end
  end

  // Dropping en clears everything on that same edge, so lock falls one edge after en=0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_good_cnt   <= '0;
      r_lock       <= 1'b0;
      r_win_cnt    <= '0;
      r_edge_cnt   <= '0;
      r_meas_count <= '0;
      r_meas_valid <= 1'b0;
      r_too_fast   <= 1'b0;
      r_too_slow   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_good_cnt <= w_good_next;
      r_lock     <= (w_state_next == ST_LOCKED);
      if (!w_active) begin
        r_win_cnt    <= '0;
        r_edge_cnt   <= '0;
        r_meas_valid <= 1'b0;
        r_too_fast   <= 1'b0;
        r_too_slow   <= 1'b0;
      end else if (w_win_end) begin
        r_win_cnt    <= '0;
        r_edge_cnt   <= '0;
        r_meas_count <= w_total;
        r_meas_valid <= 1'b1;
        r_too_fast   <= w_fast;
        r_too_slow   <= w_slow;
      end else begin
        r_win_cnt    <= r_win_cnt + 1'b1;
        r_edge_cnt   <= w_total;
        r_meas_valid <= 1'b0;
      end
    end
  end

  assign o_meas_count = r_meas_count;
  assign o_meas_valid = r_meas_valid;
  assign o_too_fast   = r_too_fast;
  assign o_too_slow   = r_too_slow;
  assign o_lock       = r_lock;

endmodule

// File: tb/tb_freq_lock_detect.sv
// Bench for freq_lock_detect: drives a generated feedback clock and compares every cycle
// against a window/edge-list reference model; a narrow-counter instance covers saturation.
module tb_freq_lock_detect;

  localparam int WINDOW    = 256;
  localparam int CNT_W     = 9;
  localparam int LOCK_WINS = 4;
  localparam int SAT_W     = 4;
  localparam int MAX_CNT   = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             en;
  logic             fb_clk;
  logic [CNT_W-1:0] expC;
  logic [CNT_W-1:0] tolC;
  logic [CNT_W-1:0] o_meas_count;
  logic             o_meas_valid;
  logic             o_too_fast;
  logic             o_too_slow;
  logic             o_lock;

  logic             enS;
  logic [SAT_W-1:0] expS;
  logic [SAT_W-1:0] tolS;
  logic [SAT_W-1:0] measS;
  logic             validS;
  logic             fastS;
  logic             slowS;
  logic             lockS;

  int nPass  = 0;
  int nTotal = 0;

  // Feedback clock generator: half period in clk cycles, 0 means hold at fbHold.
  int   fbHalf  = 0;
  int   fbPhase = 0;
  logic fbHold  = 1'b0;

  // Reference model: lvl[n] is the fb level driven after edge n; a rising level
  // driven after edge n is counted by the detector at edge n+3.
  int               cyc = 4;
  bit               lvl [0:39999];
  bit               mRun;
  int               mStart;
  int               mGood;
  bit               mValid;
  bit               mFast;
  bit               mSlow;
  logic [CNT_W-1:0] mMeas;

  freq_lock_detect #(.WINDOW(WINDOW), .CNT_W(CNT_W), .LOCK_WINS(LOCK_WINS)) dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_fb_clk(fb_clk),
    .i_exp_count(expC), .i_tol(tolC),
    .o_meas_count(o_meas_count), .o_meas_valid(o_meas_valid),
    .o_too_fast(o_too_fast), .o_too_slow(o_too_slow), .o_lock(o_lock)
  );

  freq_lock_detect #(.WINDOW(WINDOW), .CNT_W(SAT_W), .LOCK_WINS(LOCK_WINS)) dutSat (
    .i_clk(clk), .i_reset(rst), .i_en(enS), .i_fb_clk(fb_clk),
    .i_exp_count(expS), .i_tol(tolS),
    .o_meas_count(measS), .o_meas_valid(validS),
    .o_too_fast(fastS), .o_too_slow(slowS), .o_lock(lockS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CNT_W+3:0] obsVec();
    return {o_meas_valid, o_meas_count, o_too_fast, o_too_slow, o_lock};
  endfunction

  function automatic logic [CNT_W+3:0] modelVec();
    return {mValid, mMeas, mFast, mSlow, (mGood >= LOCK_WINS)};
  endfunction

  // Advance one clock: update the model with the inputs sampled at this edge, then
  // drive the next feedback level 1 time unit later.
  task automatic tick();
    int cnt, lo, hi;
    @(posedge clk);
    cyc++;
    if (rst) begin
      lvl[cyc-1] = 1'b0; lvl[cyc-2] = 1'b0; lvl[cyc-3] = 1'b0;
      mRun = 0; mGood = 0; mValid = 0; mFast = 0; mSlow = 0; mMeas = '0;
    end else if (!en) begin
      mRun = 0; mGood = 0; mValid = 0; mFast = 0; mSlow = 0;
    end else if (!mRun) begin
      mRun = 1; mStart = cyc; mValid = 0;
    end else if (cyc - mStart == WINDOW) begin
      cnt = 0;
      for (int m = mStart + 1; m <= cyc; m++)
        if (lvl[m-3] && !lvl[m-4]) cnt++;
      if (cnt > MAX_CNT) cnt = MAX_CNT;
      lo = int'(expC) - int'(tolC);
      if (lo < 0) lo = 0;
      hi = int'(expC) + int'(tolC);
      mMeas  = CNT_W'(cnt);
      mValid = 1;
      mFast  = (cnt > hi);
      mSlow  = (cnt < lo);
      mGood  = (!mFast && !mSlow) ? mGood + 1 : 0;
      mStart = cyc;
    end else begin
      mValid = 0;
    end
    #1;
    if (fbHalf == 0) begin
      fb_clk = fbHold;
    end else begin
      fbPhase++;
      if (fbPhase >= fbHalf) begin
        fbPhase = 0;
        fb_clk  = ~fb_clk;
      end
    end
    lvl[cyc] = fb_clk;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nTotal++;
      if (obsVec() !== '0) $display("[TB] FAIL reset_outputs got %h want 0", obsVec());
      else nPass++;
    end
    rst = 1'b0;
    tick();
    nTotal++;
    if (obsVec() !== modelVec()) $display("[TB] FAIL reset_release got %h want %h", obsVec(), modelVec());
    else nPass++;
  endtask

  task automatic test_nominal();
    int nWin = 0;
    int enEdge;
    expC = 16; tolC = 1; fbHalf = 8; fbPhase = 0; en = 1'b1;
    enEdge = cyc + 1;
    for (int i = 0; i < 5 * WINDOW + 4; i++) begin
      tick();
      nTotal++;
      if (obsVec() !== modelVec()) $display("[TB] FAIL nominal_cyc%0d got %h want %h", cyc, obsVec(), modelVec());
      else nPass++;
      if (o_meas_valid === 1'b1) begin
        nWin++;
        nTotal++;
        if ({o_meas_count, o_too_fast, o_too_slow, o_lock} !== {CNT_W'(16), 2'b00, (nWin >= LOCK_WINS)})
          $display("[TB] FAIL nominal_win%0d got %0d/%b%b%b want 16/00%b", nWin, o_meas_count,
                   o_too_fast, o_too_slow, o_lock, (nWin >= LOCK_WINS));
        else nPass++;
        if (nWin == 1) begin
          nTotal++;
          if (cyc - enEdge !== WINDOW) $display("[TB] FAIL first_window_latency got %0d want %0d", cyc - enEdge, WINDOW);
          else nPass++;
        end
      end
    end
    nTotal++;
    if (nWin !== 5) $display("[TB] FAIL nominal_windows got %0d want 5", nWin);
    else nPass++;
  endtask

  task automatic test_too_fast();
    int nWin = 0;
    fbHalf = 4;
    for (int i = 0; i < 2 * WINDOW; i++) begin
      tick();
      nTotal++;
      if (obsVec() !== modelVec()) $display("[TB] FAIL fast_cyc%0d got %h want %h", cyc, obsVec(), modelVec());
      else nPass++;
      if (o_meas_valid === 1'b1) begin
        nWin++;
        if (nWin == 2) begin
          nTotal++;
          if ({o_meas_count, o_too_fast, o_too_slow, o_lock} !== {CNT_W'(32), 3'b100})
            $display("[TB] FAIL fast_window got %0d/%b%b%b want 32/100", o_meas_count, o_too_fast, o_too_slow, o_lock);
          else nPass++;
        end
      end
    end
    fbHalf = 8;
    nWin = 0;
    for (int i = 0; i < 6 * WINDOW; i++) begin
      tick();
      nTotal++;
      if (obsVec() !== modelVec()) $display("[TB] FAIL relock_cyc%0d got %h want %h", cyc, obsVec(), modelVec());
      else nPass++;
      if (o_meas_valid === 1'b1) nWin++;
    end
    nTotal++;
    if ({nWin == 6, o_lock} !== 2'b11) $display("[TB] FAIL relock got win=%0d lock=%b want win=6 lock=1", nWin, o_lock);
    else nPass++;
  endtask

  task automatic test_slow_and_clamp();
    int nWin = 0;
    fbHalf = 0; fbHold = 1'b0;
    for (int i = 0; i < 5 * WINDOW; i++) begin
      tick();
      nTotal++;
      if (obsVec() !== modelVec()) $display("[TB] FAIL slow_cyc%0d got %h want %h", cyc, obsVec(), modelVec());
      else nPass++;
      if (o_meas_valid === 1'b1) begin
        nWin++;
        if (nWin >= 2) begin
          nTotal++;
          if ({o_meas_count, o_too_fast, o_too_slow, o_lock} !== {CNT_W'(0), 3'b010})
            $display("[TB] FAIL slow_win%0d got %0d/%b%b%b want 0/010", nWin, o_meas_count, o_too_fast, o_too_slow, o_lock);
          else nPass++;
        end
      end
    end
    expC = 0; tolC = 0;
    nWin = 0;
    for (int i = 0; i < 5 * WINDOW; i++) begin
      tick();
      nTotal++;
      if (obsVec() !== modelVec()) $display("[TB] FAIL clamp_cyc%0d got %h want %h", cyc, obsVec(), modelVec());
      else nPass++;
      if (o_meas_valid === 1'b1) begin
        nWin++;
        nTotal++;
        if ({o_meas_count, o_too_fast, o_too_slow, o_lock} !== {CNT_W'(0), 2'b00, (nWin >= LOCK_WINS)})
          $display("[TB] FAIL clamp_win%0d got %0d/%b%b%b want 0/00%b", nWin, o_meas_count,
                   o_too_fast, o_too_slow, o_lock, (nWin >= LOCK_WINS));
        else nPass++;
      end
    end
  endtask

  task automatic test_saturate();
    bit found = 0;
    int want;
    en = 1'b0; fbHalf = 2; enS = 1'b1; expS = 8; tolS = 2;
    want = (WINDOW / 4 > 15) ? 15 : WINDOW / 4;
    for (int i = 0; i < WINDOW + 20 && !found; i++) begin
      tick();
      nTotal++;
      if (obsVec() !== modelVec()) $display("[TB] FAIL sat_main_cyc%0d got %h want %h", cyc, obsVec(), modelVec());
      else nPass++;
      if (validS === 1'b1) begin
        found = 1;
        nTotal++;
        if ({measS, fastS, slowS, lockS} !== {SAT_W'(want), 3'b100})
          $display("[TB] FAIL saturate got %0d/%b%b%b want %0d/100", measS, fastS, slowS, lockS, want);
        else nPass++;
      end
    end
    nTotal++;
    if (!found) $display("[TB] FAIL saturate_timeout got none want meas_valid");
    else nPass++;
    enS = 1'b0;
  endtask

  task automatic test_en_drop();
    bit found = 0;
    int enEdge;
    en = 1'b1; expC = 16; tolC = 1; fbHalf = 8;
    for (int i = 0; i < 5 * WINDOW + 100; i++) begin
      tick();
      nTotal++;
      if (obsVec() !== modelVec()) $display("[TB] FAIL drop_lock_cyc%0d got %h want %h", cyc, obsVec(), modelVec());
      else nPass++;
    end
    nTotal++;
    if (o_lock !== 1'b1) $display("[TB] FAIL drop_prelock got %b want 1", o_lock);
    else nPass++;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      nTotal++;
      if ({o_lock, o_meas_valid} !== 2'b00) $display("[TB] FAIL drop_idle got lock=%b valid=%b want 00", o_lock, o_meas_valid);
      else nPass++;
    end
    en = 1'b1;
    enEdge = cyc + 1;
    for (int i = 0; i < WINDOW + 20 && !found; i++) begin
      tick();
      nTotal++;
      if (obsVec() !== modelVec()) $display("[TB] FAIL drop_resume_cyc%0d got %h want %h", cyc, obsVec(), modelVec());
      else nPass++;
      if (o_meas_valid === 1'b1) begin
        found = 1;
        nTotal++;
        if (cyc - enEdge !== WINDOW) $display("[TB] FAIL drop_latency got %0d want %0d", cyc - enEdge, WINDOW);
        else nPass++;
      end
    end
    nTotal++;
    if (!found) $display("[TB] FAIL drop_timeout got none want meas_valid");
    else nPass++;
  endtask

  task automatic test_reset_locked();
    bit found = 0;
    int enEdge;
    for (int i = 0; i < 4 * WINDOW; i++) begin
      tick();
      nTotal++;
      if (obsVec() !== modelVec()) $display("[TB] FAIL rstlock_cyc%0d got %h want %h", cyc, obsVec(), modelVec());
      else nPass++;
    end
    nTotal++;
    if (o_lock !== 1'b1) $display("[TB] FAIL rstlock_prelock got %b want 1", o_lock);
    else nPass++;
    rst = 1'b1;
    tick();
    nTotal++;
    if (obsVec() !== '0) $display("[TB] FAIL rstlock_outputs got %h want 0", obsVec());
    else nPass++;
    rst = 1'b0;
    enEdge = cyc + 1;
    for (int i = 0; i < WINDOW + 20 && !found; i++) begin
      tick();
      nTotal++;
      if (obsVec() !== modelVec()) $display("[TB] FAIL rstlock_resume_cyc%0d got %h want %h", cyc, obsVec(), modelVec());
      else nPass++;
      if (o_meas_valid === 1'b1) begin
        found = 1;
        nTotal++;
        if ({cyc - enEdge == WINDOW, o_lock} !== 2'b10)
          $display("[TB] FAIL rstlock_latency got %0d lock=%b want %0d lock=0", cyc - enEdge, o_lock, WINDOW);
        else nPass++;
      end
    end
    nTotal++;
    if (!found) $display("[TB] FAIL rstlock_timeout got none want meas_valid");
    else nPass++;
  endtask

  task automatic test_random();
    int base, e, n, offCycles;
    for (int w = 0; w < 20; w++) begin
      if ($urandom_range(0, 5) == 0) begin
        fbHalf = 0;
        fbHold = fb_clk;
      end else begin
        fbHalf = int'($urandom_range(2, 12));
      end
      base = (fbHalf != 0) ? WINDOW / (2 * fbHalf) : 0;
      e = base + int'($urandom_range(0, 4)) - 2;
      if (e < 0) e = 0;
      expC = CNT_W'(e);
      tolC = CNT_W'($urandom_range(0, 3));
      offCycles = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 20)) : 0;
      n = int'($urandom_range(100, 400));
      for (int i = 0; i < n; i++) begin
        if (i == 0 && offCycles != 0) en = 1'b0;
        if (i == offCycles) en = 1'b1;
        tick();
        nTotal++;
        if (obsVec() !== modelVec()) $display("[TB] FAIL random_cyc%0d got %h want %h", cyc, obsVec(), modelVec());
        else nPass++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; enS = 1'b0; fb_clk = 1'b0;
    expC = '0; tolC = '0; expS = '0; tolS = '0;
    mRun = 0; mStart = 0; mGood = 0; mValid = 0; mFast = 0; mSlow = 0; mMeas = '0;
    $display("[TB] freq_lock_detect bench start");
    test_reset();
    test_nominal();
    test_too_fast();
    test_slow_and_clamp();
    test_saturate();
    test_en_drop();
    test_reset_locked();
    test_random();
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule

// File: doc/freq_lock_detect.md
# freq_lock_detect

Frequency lock detector that consumes a divided feedback clock (e.g. the /16 tap of the clock divider) in the PLL loop. It counts rising edges of that clock over a fixed window of system clocks and compares the count with a programmed expected value and tolerance. It reports the measurement, fast/slow flags and a hysteretic `lock` indication to loop control.

## Interface
- `WINDOW`, 256: window length in `clk` cycles (≥2).
- `CNT_W`, 9: width of edge counter and measurement.
- `LOCK_WINS`, 4: consecutive in-range windows required to assert `lock` (≥1).
- `clk` in 1: system clock; all logic on posedge.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: measurement enable; 0 forces IDLE.
- `fb_clk` in 1: divided feedback clock, asynchronous to `clk`, sampled as data.
- `exp_count` in CNT_W: expected edges per window.
- `tol` in CNT_W: allowed ± deviation.
- `meas_count` out CNT_W: edge count of last completed window.
- `meas_valid` out 1: one-cycle pulse when `meas_count` updates.
- `too_fast` out 1: last window count > exp_count+tol.
- `too_slow` out 1: last window count < exp_count−tol.
- `lock` out 1: frequency locked.

## Operation
- Synchronizer: `fb_clk` → s1 → s2 → s3, free-running outside reset. Edge pulse = s2 & ~s3.
- Window counter `win_cnt` runs 0..WINDOW−1 while `en`=1 and wraps. It is cleared in IDLE.
- Edge counter adds 1 per edge pulse while `en`=1. It saturates at 2^CNT_W−1 and does not wrap.
- Window end is when `win_cnt`=WINDOW−1. At that edge:
  - total = edge_cnt + edge pulse of that cycle, saturating; `meas_count` ← total.
  - edge_cnt ← 0.
  - `meas_valid` ← 1.
  - Flags and state are updated together.
- Compare in CNT_W+1 bits with no wrap. Low bound = exp_count−tol, clamped at 0. High bound = exp_count+tol.
  - in_range = low ≤ total ≤ high.
  - `too_fast`/`too_slow` are registered and hold until the next window end.
- `exp_count` and `tol` are used as presented at the window-end edge and are not latched.
- State machine:
  - IDLE: entered on reset or `en`=0. Clears win_cnt, edge_cnt, good_cnt, `lock`, flags and `meas_valid`. `meas_count` holds.
  - IDLE → ACQUIRE when `en`=1. The window starts with win_cnt=0 on the next edge.
  - ACQUIRE, window end, in_range: good_cnt+1. If good_cnt reaches LOCK_WINS, go to LOCKED with `lock`=1.
  - ACQUIRE, window end, out of range: good_cnt ← 0.
  - LOCKED, window end, in_range: stay.
  - LOCKED, window end, out of range: go to ACQUIRE with `lock`=0 and good_cnt=0. A single bad window drops lock.
  - `en`=0 in any state: go to IDLE on the next edge.
- Reset: all registers 0. Every output is 0 after reset.

## Timing
- `fb_clk` high and low phases must each be ≥2 `clk` periods to be counted exactly. Faster inputs give undefined counts.
- Latency: a `fb_clk` level first seen high at posedge k produces an edge counted at posedge k+2.
- The first window ends WINDOW cycles after the first `en`=1 edge in IDLE.
- `meas_valid`, `meas_count`, flags and `lock` all change on the same window-end edge. `meas_valid` is high for exactly 1 cycle.
- `lock` rises on the window-end edge of the LOCK_WINS-th consecutive good window. It falls on the window-end edge of a bad window, or one edge after `en`=0 or `reset`.
- `en` falling mid-window discards the partial window. No `meas_valid` is issued.
- `reset` overrides `en`, mid-window or while locked.

## Test plan
- WINDOW=256, exp=16, tol=1, `fb_clk`=clk/16, `en`=1 → `meas_valid` pulses every 256 cycles with `meas_count`=16 and flags 0. `lock` rises at the 4th window end, ≈1024 cycles after `en`.
- Locked, then `fb_clk` switched to clk/8 → next full window `meas_count`=32, `too_fast`=1, `lock`=0. Back to clk/16 → relock after 4 more good windows.
- `fb_clk` held 0 → `meas_count`=0, `too_slow`=1, `lock` never asserts. exp=0, tol=0 → in_range, lock after 4 windows (clamp check).
- CNT_W=4, `fb_clk`=clk/4, WINDOW=256 → `meas_count`=15 (saturated), `too_fast`=1 with exp=8, tol=2.
- Locked, `en` dropped mid-window for 10 cycles → `lock`=0 the next cycle, no `meas_valid`. On re-enable the first `meas_valid` arrives exactly 256 cycles later.
- `reset` pulsed while locked → all outputs 0 the next cycle. `en` held high resumes acquisition from win_cnt=0.
